// File: rtl/uart_tx_serializer_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : uart_tx_serializer_if
// Description : UART TX request bundle between the MMIO controller (master)
//               and the TX serializer (slave).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
interface uart_tx_serializer_if #(
    parameter int FIFO_DEPTH = 4
);
    logic                        tx_start;
    logic [7:0]                  tx_data;
    logic                        tx_busy;
    logic                        tx_overflow;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;

    modport master (
        output tx_start,
        output tx_data,
        input  tx_busy,
        input  tx_overflow,
        input  fifo_level
    );

    modport slave (
        input  tx_start,
        input  tx_data,
        output tx_busy,
        output tx_overflow,
        output fifo_level
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : uart_tx_serializer
// Description : Byte FIFO feeding an async serial framer: start bit, 8 data
//               bits LSB first, optional parity, 1-2 stop bits. Idle line high.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    uart_tx_serializer_if.slave   bus,
    output logic                  tx_serial,
    output logic                  tx_active,
    output logic                  tx_done
);

    localparam int c_ptr_w  = $clog2(FIFO_DEPTH);
    localparam int c_lvl_w  = c_ptr_w + 1;
    localparam int c_baud_w = $clog2(CLKS_PER_BIT);

    localparam logic [c_lvl_w-1:0]  c_depth     = c_lvl_w'(FIFO_DEPTH);
    localparam logic [c_baud_w-1:0] c_baud_last = c_baud_w'(CLKS_PER_BIT - 1);
    localparam logic [c_baud_w-1:0] c_baud_pre  = c_baud_w'(CLKS_PER_BIT - 2);
    localparam logic [2:0]          c_stop_last = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]          r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]  r_wr_ptr;
    logic [c_ptr_w-1:0]  r_rd_ptr;
    logic [c_lvl_w-1:0]  r_level;
    logic                r_full;
    logic                r_overflow;
    logic [c_lvl_w-1:0]  w_level_next;

    // Framer state
    state_t              r_state;
    logic [c_baud_w-1:0] r_baud;
    logic [2:0]          r_bit_idx;
    logic [7:0]          r_shift;
    logic                r_parity_bit;
    logic                r_tx_serial;
    logic                r_tx_active;
    logic                r_tx_done;

    logic                w_push;
    logic                w_pop;
    logic                w_nonempty;
    logic                w_baud_last;
    logic                w_last_stop;
    logic [7:0]          w_head;
    logic                w_head_parity;

    // Push looks only at the registered full flag, so a same-cycle pop never frees a slot
    assign w_push        = bus.tx_start && !r_full;
    assign w_nonempty    = (r_level != '0);
    assign w_baud_last   = (r_baud == c_baud_last);
    assign w_last_stop   = (r_bit_idx == c_stop_last);
    assign w_head        = r_mem[r_rd_ptr];
    // Parity is taken from the byte as popped, before any shifting
    assign w_head_parity = (PARITY_ODD != 0) ? ~^w_head : ^w_head;
    assign w_pop         = w_nonempty &&
                           ((r_state == S_IDLE) ||
                            (r_state == S_STOP && w_baud_last && w_last_stop));

    // Next FIFO occupancy; push and pop together cancel out
    always_comb begin
        w_level_next = r_level;
        unique case ({w_push, w_pop})
            2'b10:   w_level_next = r_level + 1'b1;
            2'b01:   w_level_next = r_level - 1'b1;
            default: w_level_next = r_level;
        endcase
    end

    // FIFO data array; contents need no reset because the level gates every read
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.tx_data;
        end
    end

    // FIFO pointers, level, full flag and overflow pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_level    <= w_level_next;
            r_full     <= (w_level_next == c_depth);
            r_overflow <= bus.tx_start && r_full;
        end
    end

    // Frame sequencer; every output is registered alongside the state it belongs to
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_baud       <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_parity_bit <= 1'b0;
            r_tx_serial  <= 1'b1;
            r_tx_active  <= 1'b0;
            r_tx_done    <= 1'b0;
        end else begin
            r_tx_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    r_tx_serial <= 1'b1;
                    r_tx_active <= 1'b0;
                    if (w_pop) begin
                        r_shift      <= w_head;
                        r_parity_bit <= w_head_parity;
                        r_baud       <= '0;
                        r_state      <= S_START;
                        r_tx_serial  <= 1'b0;
                        r_tx_active  <= 1'b1;
                    end
                end
                S_START: begin
                    if (w_baud_last) begin
                        r_baud      <= '0;
                        r_bit_idx   <= '0;
                        r_state     <= S_DATA;
                        r_tx_serial <= r_shift[0];
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_baud_last) begin
                        r_baud <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_bit_idx <= '0;
                            if (PARITY_EN != 0) begin
                                r_state     <= S_PARITY;
                                r_tx_serial <= r_parity_bit;
                            end else begin
                                r_state     <= S_STOP;
                                r_tx_serial <= 1'b1;
                            end
                        end else begin
                            r_bit_idx   <= r_bit_idx + 3'd1;
                            r_shift     <= {1'b0, r_shift[7:1]};
                            r_tx_serial <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (w_baud_last) begin
                        r_baud      <= '0;
                        r_bit_idx   <= '0;
                        r_state     <= S_STOP;
                        r_tx_serial <= 1'b1;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_STOP: begin
                    // Raise done so it is visible during the final stop-bit cycle
                    if (w_last_stop && (r_baud == c_baud_pre)) begin
                        r_tx_done <= 1'b1;
                    end
                    if (w_baud_last) begin
                        r_baud <= '0;
                        if (w_last_stop) begin
                            r_bit_idx <= '0;
                            if (w_pop) begin
                                r_shift      <= w_head;
                                r_parity_bit <= w_head_parity;
                                r_state      <= S_START;
                                r_tx_serial  <= 1'b0;
                            end else begin
                                r_state     <= S_IDLE;
                                r_tx_serial <= 1'b1;
                                r_tx_active <= 1'b0;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_tx_serial <= 1'b1;
                    r_tx_active <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tx_busy     = r_full;
    assign bus.tx_overflow = r_overflow;
    assign bus.fifo_level  = r_level;
    assign tx_serial       = r_tx_serial;
    assign tx_active       = r_tx_active;
    assign tx_done         = r_tx_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_uart_tx_serializer
// Description : Directed self-checking bench for uart_tx_serializer. Four
//               instances share stimulus: plain, even parity, odd parity and
//               two stop bits, all with CLKS_PER_BIT=4 and FIFO_DEPTH=4.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_uart_tx_serializer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tb_start = 1'b0;
    logic [7:0] tb_data = 8'h00;
    int         n_checks = 0;
    int         n_fail = 0;

    wire [3:0]  ser;
    wire [3:0]  act;
    wire [3:0]  done;

    always #5 clk = ~clk;

    uart_tx_serializer_if #(.FIFO_DEPTH(4)) u_if0 ();
    uart_tx_serializer_if #(.FIFO_DEPTH(4)) u_if1 ();
    uart_tx_serializer_if #(.FIFO_DEPTH(4)) u_if2 ();
    uart_tx_serializer_if #(.FIFO_DEPTH(4)) u_if3 ();

    assign u_if0.tx_start = tb_start;
    assign u_if0.tx_data  = tb_data;
    assign u_if1.tx_start = tb_start;
    assign u_if1.tx_data  = tb_data;
    assign u_if2.tx_start = tb_start;
    assign u_if2.tx_data  = tb_data;
    assign u_if3.tx_start = tb_start;
    assign u_if3.tx_data  = tb_data;

    uart_tx_serializer #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
        u_dut0 (.clk(clk), .rst_n(rst_n), .bus(u_if0), .tx_serial(ser[0]), .tx_active(act[0]), .tx_done(done[0]));
    uart_tx_serializer #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
        u_dut1 (.clk(clk), .rst_n(rst_n), .bus(u_if1), .tx_serial(ser[1]), .tx_active(act[1]), .tx_done(done[1]));
    uart_tx_serializer #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1))
        u_dut2 (.clk(clk), .rst_n(rst_n), .bus(u_if2), .tx_serial(ser[2]), .tx_active(act[2]), .tx_done(done[2]));
    uart_tx_serializer #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2))
        u_dut3 (.clk(clk), .rst_n(rst_n), .bus(u_if3), .tx_serial(ser[3]), .tx_active(act[3]), .tx_done(done[3]));

    // Hold reset for two edges; returns on a falling edge with reset released
    task automatic do_reset();
        tb_start = 1'b0;
        tb_data  = 8'h00;
        rst_n    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        tb_start = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (ser[k] !== 1'b1) begin n_fail++; $display("FAIL reset_serial dut%0d got %b exp 1", k, ser[k]); end
            n_checks++; if (act[k] !== 1'b0) begin n_fail++; $display("FAIL reset_active dut%0d got %b exp 0", k, act[k]); end
            n_checks++; if (done[k] !== 1'b0) begin n_fail++; $display("FAIL reset_done dut%0d got %b exp 0", k, done[k]); end
        end
        n_checks++; if (u_if0.tx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", u_if0.tx_busy); end
        n_checks++; if (u_if0.tx_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b exp 0", u_if0.tx_overflow); end
        n_checks++; if (u_if0.fifo_level !== 3'd0) begin n_fail++; $display("FAIL reset_level got %0d exp 0", u_if0.fifo_level); end
        n_checks++; if (u_if3.fifo_level !== 3'd0) begin n_fail++; $display("FAIL reset_level3 got %0d exp 0", u_if3.fifo_level); end
        rst_n = 1'b1;
    endtask

    // One 0xA5 frame: 0,1,0,1,0,0,1,0,1,1 each held four cycles, done on cycle 40
    task automatic test_single_frame();
        logic [9:0] fr;
        fr = {1'b1, 8'hA5, 1'b0};
        do_reset();
        tb_start = 1'b1;
        tb_data  = 8'hA5;
        @(negedge clk);
        tb_start = 1'b0;
        n_checks++; if (u_if0.fifo_level !== 3'd1) begin n_fail++; $display("FAIL single_level got %0d exp 1", u_if0.fifo_level); end
        n_checks++; if (ser[0] !== 1'b1) begin n_fail++; $display("FAIL single_pre_serial got %b exp 1", ser[0]); end
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            n_checks++; if (ser[0] !== fr[(i-1)/4]) begin n_fail++; $display("FAIL single_serial cyc %0d got %b exp %b", i, ser[0], fr[(i-1)/4]); end
            n_checks++; if (done[0] !== (i == 40)) begin n_fail++; $display("FAIL single_done cyc %0d got %b exp %b", i, done[0], (i == 40)); end
            n_checks++; if (act[0] !== 1'b1) begin n_fail++; $display("FAIL single_active cyc %0d got %b exp 1", i, act[0]); end
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++; if (ser[0] !== 1'b1) begin n_fail++; $display("FAIL single_idle_serial got %b exp 1", ser[0]); end
            n_checks++; if (act[0] !== 1'b0) begin n_fail++; $display("FAIL single_idle_active got %b exp 0", act[0]); end
        end
    endtask

    // 0x07 has three ones: even parity bit 1, odd parity bit 0, 44-cycle frame
    task automatic test_parity();
        logic [10:0] fr_e;
        logic [10:0] fr_o;
        fr_e = {1'b1, 1'b1, 8'h07, 1'b0};
        fr_o = {1'b1, 1'b0, 8'h07, 1'b0};
        do_reset();
        tb_start = 1'b1;
        tb_data  = 8'h07;
        @(negedge clk);
        tb_start = 1'b0;
        for (int i = 1; i <= 44; i++) begin
            @(negedge clk);
            n_checks++; if (ser[1] !== fr_e[(i-1)/4]) begin n_fail++; $display("FAIL parity_even cyc %0d got %b exp %b", i, ser[1], fr_e[(i-1)/4]); end
            n_checks++; if (ser[2] !== fr_o[(i-1)/4]) begin n_fail++; $display("FAIL parity_odd cyc %0d got %b exp %b", i, ser[2], fr_o[(i-1)/4]); end
            n_checks++; if (done[1] !== (i == 44)) begin n_fail++; $display("FAIL parity_even_done cyc %0d got %b exp %b", i, done[1], (i == 44)); end
            n_checks++; if (done[2] !== (i == 44)) begin n_fail++; $display("FAIL parity_odd_done cyc %0d got %b exp %b", i, done[2], (i == 44)); end
        end
        @(negedge clk);
        n_checks++; if (act[1] !== 1'b0) begin n_fail++; $display("FAIL parity_even_idle got %b exp 0", act[1]); end
        n_checks++; if (act[2] !== 1'b0) begin n_fail++; $display("FAIL parity_odd_idle got %b exp 0", act[2]); end
    endtask

    // Six pushes 0x11..0x16: five accepted, sixth dropped, five frames back-to-back
    task automatic test_back_to_back();
        logic [9:0] fr;
        logic [7:0] b;
        int         ov_count;
        int         done_count;
        int         i;
        ov_count   = 0;
        done_count = 0;
        do_reset();
        for (int j = 0; j <= 206; j++) begin
            if (j >= 1) begin
                if (u_if0.tx_overflow === 1'b1) ov_count++;
                if (done[0] === 1'b1) done_count++;
            end
            if (j == 4) begin
                n_checks++; if (u_if0.tx_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_before got %b exp 0", u_if0.tx_busy); end
                n_checks++; if (u_if0.fifo_level !== 3'd3) begin n_fail++; $display("FAIL b2b_level_3 got %0d exp 3", u_if0.fifo_level); end
            end
            if (j == 5) begin
                n_checks++; if (u_if0.tx_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_full got %b exp 1", u_if0.tx_busy); end
                n_checks++; if (u_if0.fifo_level !== 3'd4) begin n_fail++; $display("FAIL b2b_level_4 got %0d exp 4", u_if0.fifo_level); end
            end
            if (j == 6) begin
                n_checks++; if (u_if0.tx_overflow !== 1'b1) begin n_fail++; $display("FAIL b2b_overflow got %b exp 1", u_if0.tx_overflow); end
                n_checks++; if (u_if0.fifo_level !== 3'd4) begin n_fail++; $display("FAIL b2b_level_drop got %0d exp 4", u_if0.fifo_level); end
            end
            if (j == 7) begin
                n_checks++; if (u_if0.tx_overflow !== 1'b0) begin n_fail++; $display("FAIL b2b_overflow_clear got %b exp 0", u_if0.tx_overflow); end
            end
            if (j >= 2 && j <= 201) begin
                i  = j - 1;
                b  = 8'h11 + 8'((i - 1) / 40);
                fr = {1'b1, b, 1'b0};
                n_checks++; if (ser[0] !== fr[((i-1)%40)/4]) begin n_fail++; $display("FAIL b2b_serial cyc %0d got %b exp %b", i, ser[0], fr[((i-1)%40)/4]); end
                n_checks++; if (act[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_active cyc %0d got %b exp 1", i, act[0]); end
            end
            if (j >= 202) begin
                n_checks++; if (ser[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_idle_serial got %b exp 1", ser[0]); end
                n_checks++; if (act[0] !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_active got %b exp 0", act[0]); end
            end
            tb_start = (j < 6);
            tb_data  = 8'h11 + 8'(j);
            @(negedge clk);
        end
        tb_start = 1'b0;
        n_checks++; if (ov_count != 1) begin n_fail++; $display("FAIL b2b_overflow_pulses got %0d exp 1", ov_count); end
        n_checks++; if (done_count != 5) begin n_fail++; $display("FAIL b2b_done_pulses got %0d exp 5", done_count); end
    endtask

    // Two stop bits, 0x00: 4 low (start), 32 low (data), 8 high, done on cycle 44
    task automatic test_stop_bits();
        logic [10:0] fr;
        fr = {2'b11, 8'h00, 1'b0};
        do_reset();
        tb_start = 1'b1;
        tb_data  = 8'h00;
        @(negedge clk);
        tb_start = 1'b0;
        for (int i = 1; i <= 44; i++) begin
            @(negedge clk);
            n_checks++; if (ser[3] !== fr[(i-1)/4]) begin n_fail++; $display("FAIL stop2_serial cyc %0d got %b exp %b", i, ser[3], fr[(i-1)/4]); end
            n_checks++; if (done[3] !== (i == 44)) begin n_fail++; $display("FAIL stop2_done cyc %0d got %b exp %b", i, done[3], (i == 44)); end
        end
        @(negedge clk);
        n_checks++; if (act[3] !== 1'b0) begin n_fail++; $display("FAIL stop2_idle got %b exp 0", act[3]); end
    endtask

    // Reset while in DATA with two bytes queued aborts everything
    task automatic test_reset_mid_frame();
        do_reset();
        for (int j = 0; j <= 70; j++) begin
            if (j == 3) begin
                n_checks++; if (u_if0.fifo_level !== 3'd2) begin n_fail++; $display("FAIL midrst_level_pre got %0d exp 2", u_if0.fifo_level); end
            end
            if (j == 10) begin
                n_checks++; if (act[0] !== 1'b1) begin n_fail++; $display("FAIL midrst_active_pre got %b exp 1", act[0]); end
            end
            if (j == 11) begin
                n_checks++; if (ser[0] !== 1'b1) begin n_fail++; $display("FAIL midrst_serial got %b exp 1", ser[0]); end
                n_checks++; if (u_if0.fifo_level !== 3'd0) begin n_fail++; $display("FAIL midrst_level got %0d exp 0", u_if0.fifo_level); end
                n_checks++; if (act[0] !== 1'b0) begin n_fail++; $display("FAIL midrst_active got %b exp 0", act[0]); end
                n_checks++; if (u_if0.tx_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b exp 0", u_if0.tx_busy); end
            end
            if (j >= 11) begin
                n_checks++; if (done[0] !== 1'b0) begin n_fail++; $display("FAIL midrst_done j %0d got %b exp 0", j, done[0]); end
                n_checks++; if (ser[0] !== 1'b1) begin n_fail++; $display("FAIL midrst_line j %0d got %b exp 1", j, ser[0]); end
            end
            tb_start = (j < 3);
            tb_data  = 8'h31 + 8'(j);
            rst_n    = (j != 10);
            @(negedge clk);
        end
        tb_start = 1'b0;
        rst_n    = 1'b1;
    endtask

    // Full FIFO: a push on the pop edge is still rejected
    task automatic test_full_pop();
        do_reset();
        for (int j = 0; j <= 44; j++) begin
            if (j == 41) begin
                n_checks++; if (u_if0.fifo_level !== 3'd4) begin n_fail++; $display("FAIL fullpop_level_pre got %0d exp 4", u_if0.fifo_level); end
                n_checks++; if (u_if0.tx_busy !== 1'b1) begin n_fail++; $display("FAIL fullpop_busy_pre got %b exp 1", u_if0.tx_busy); end
                n_checks++; if (done[0] !== 1'b1) begin n_fail++; $display("FAIL fullpop_done got %b exp 1", done[0]); end
            end
            if (j == 42) begin
                n_checks++; if (u_if0.tx_overflow !== 1'b1) begin n_fail++; $display("FAIL fullpop_overflow got %b exp 1", u_if0.tx_overflow); end
                n_checks++; if (u_if0.fifo_level !== 3'd3) begin n_fail++; $display("FAIL fullpop_level got %0d exp 3", u_if0.fifo_level); end
                n_checks++; if (u_if0.tx_busy !== 1'b0) begin n_fail++; $display("FAIL fullpop_busy got %b exp 0", u_if0.tx_busy); end
                n_checks++; if (ser[0] !== 1'b0) begin n_fail++; $display("FAIL fullpop_next_start got %b exp 0", ser[0]); end
            end
            if (j == 43) begin
                n_checks++; if (u_if0.tx_overflow !== 1'b0) begin n_fail++; $display("FAIL fullpop_overflow_clear got %b exp 0", u_if0.tx_overflow); end
                n_checks++; if (u_if0.fifo_level !== 3'd3) begin n_fail++; $display("FAIL fullpop_level_hold got %0d exp 3", u_if0.fifo_level); end
            end
            tb_start = (j < 5) || (j == 41);
            tb_data  = (j == 41) ? 8'hEE : 8'h41 + 8'(j);
            @(negedge clk);
        end
        tb_start = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_parity();
        test_back_to_back();
        test_stop_bits();
        test_reset_mid_frame();
        test_full_pop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
